// File: rtl/decode_queue.sv
// decode_queue
// Buffered instruction-decode stage between fetch and execute. Each raw
// instruction is decoded at enqueue time and the decoded record is stored in
// a small FIFO. Execute sees the oldest record on the out_* ports. A flush
// empties the queue at the next clock edge so that a branch or jump can
// redirect fetch.
//
// Ports
//   clk, rst_n         clock (rising edge) and asynchronous active-low reset
//   flush              synchronous clear; drops any push or pop this cycle
//   in_valid/in_ready  fetch handshake
//   in_instr, in_pc    raw 32-bit instruction and its address
//   out_valid/out_ready execute handshake for the head entry
//   out_pc ... out_illegal  decoded head entry; all zero while empty
//   occupancy          number of valid entries held
module decode_queue #(
   parameter int DEPTH         = 2,
   parameter int PC_WIDTH      = 32,
   parameter bit CHECK_ILLEGAL = 1'b1
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         flush,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [31:0]                  in_instr,
   input  logic [PC_WIDTH-1:0]          in_pc,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [PC_WIDTH-1:0]          out_pc,
   output logic [6:0]                   out_opcode,
   output logic [2:0]                   out_funct3,
   output logic [6:0]                   out_funct7,
   output logic [4:0]                   out_rd,
   output logic [4:0]                   out_rs1,
   output logic [4:0]                   out_rs2,
   output logic [31:0]                  out_imm,
   output logic [3:0]                   out_alu_control,
   output logic                         out_illegal,
   output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

   localparam int OCC_W = $clog2(DEPTH + 1);
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef enum logic [6:0] {
      OP_RTYPE       = 7'b0110011,
      OP_ITYPE_LOGIC = 7'b0010011,
      OP_ITYPE_LOAD  = 7'b0000011,
      OP_ITYPE_JALR  = 7'b1100111,
      OP_STYPE       = 7'b0100011,
      OP_BTYPE       = 7'b1100011,
      OP_UTYPE_AUIPC = 7'b0010111,
      OP_UTYPE_LUI   = 7'b0110111,
      OP_JTYPE       = 7'b1101111
   } opcode_t;

   typedef enum logic [1:0] {
      MEMORY_ACCESS      = 2'b00,
      BRANCH             = 2'b01,
      REGISTER_OPERATION = 2'b10,
      UNSET              = 2'b11
   } alu_op_t;

   typedef logic [31:0] imm_t;

   typedef struct packed {
      logic [PC_WIDTH-1:0] pc;
      logic [6:0]          opcode;
      logic [2:0]          funct3;
      logic [6:0]          funct7;
      logic [4:0]          rd;
      logic [4:0]          rs1;
      logic [4:0]          rs2;
      imm_t                imm;
      logic [3:0]          alu_control;
      logic                illegal;
   } entry_t;

   // ALU decoder: address arithmetic adds, branches compare by subtracting,
   // register ops are selected by funct3 with funct7[5] picking sub/sra.
   // Anything without a defined ALU role gets the no-op code.
   function automatic logic [3:0] alu_decoder(input alu_op_t op,
                                              input logic [2:0] f3,
                                              input logic f7_5);
      logic [3:0] ctl;
      ctl = 4'hF;
      case (op)
         MEMORY_ACCESS: ctl = 4'h0;
         BRANCH:        ctl = 4'h1;
         REGISTER_OPERATION: begin
            case (f3)
               3'b000:  ctl = f7_5 ? 4'h1 : 4'h0;
               3'b001:  ctl = 4'h2;
               3'b010:  ctl = 4'h3;
               3'b011:  ctl = 4'h4;
               3'b100:  ctl = 4'h5;
               3'b101:  ctl = f7_5 ? 4'h7 : 4'h6;
               3'b110:  ctl = 4'h8;
               default: ctl = 4'h9;
            endcase
         end
         default:       ctl = 4'hF;
      endcase
      return ctl;
   endfunction

   logic [2:0] f3;
   logic [6:0] f7;
   imm_t       imm_i;
   imm_t       imm_s;
   imm_t       imm_b;
   imm_t       imm_j;
   imm_t       imm_u;

   assign f3    = in_instr[14:12];
   assign f7    = in_instr[31:25];
   assign imm_i = {{20{in_instr[31]}}, in_instr[31:20]};
   assign imm_s = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
   assign imm_b = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                   in_instr[30:25], in_instr[11:8], 1'b0};
   assign imm_j = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                   in_instr[20], in_instr[30:21], 1'b0};
   assign imm_u = {in_instr[31:12], 12'b0};

   entry_t  dec;
   alu_op_t alu_op;
   logic    unknown_op;
   logic    bad_fields;

   // Decode the incoming instruction into the record stored in the queue.
   // Fields an instruction format does not use stay zero. Illegal encodings
   // are still queued, but their register indices and immediate are cleared
   // so execute never sees a phantom register write or hazard.
   always_comb begin
      dec         = '0;
      dec.pc      = in_pc;
      dec.opcode  = in_instr[6:0];
      alu_op      = UNSET;
      unknown_op  = 1'b0;
      bad_fields  = 1'b0;
      case (in_instr[6:0])
         OP_RTYPE: begin
            dec.rd     = in_instr[11:7];
            dec.rs1    = in_instr[19:15];
            dec.rs2    = in_instr[24:20];
            dec.funct3 = f3;
            dec.funct7 = f7;
            alu_op     = REGISTER_OPERATION;
            bad_fields = !((f7 == 7'h00) ||
                           ((f7 == 7'h20) && ((f3 == 3'b000) || (f3 == 3'b101))));
         end
         OP_ITYPE_LOGIC: begin
            dec.rd     = in_instr[11:7];
            dec.rs1    = in_instr[19:15];
            dec.funct3 = f3;
            dec.funct7 = f7;
            dec.imm    = imm_i;
            bad_fields = ((f3 == 3'b001) && (f7 != 7'h00)) ||
                         ((f3 == 3'b101) && (f7 != 7'h00) && (f7 != 7'h20));
         end
         OP_ITYPE_LOAD: begin
            dec.rd     = in_instr[11:7];
            dec.rs1    = in_instr[19:15];
            dec.funct3 = f3;
            dec.imm    = imm_i;
            alu_op     = MEMORY_ACCESS;
            bad_fields = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
         end
         OP_ITYPE_JALR: begin
            dec.rd     = in_instr[11:7];
            dec.rs1    = in_instr[19:15];
            dec.funct3 = f3;
            dec.imm    = imm_i;
            alu_op     = MEMORY_ACCESS;
            bad_fields = (f3 != 3'b000);
         end
         OP_STYPE: begin
            dec.rs1    = in_instr[19:15];
            dec.rs2    = in_instr[24:20];
            dec.funct3 = f3;
            dec.imm    = imm_s;
            alu_op     = MEMORY_ACCESS;
            bad_fields = (f3 > 3'b010);
         end
         OP_BTYPE: begin
            dec.rs1    = in_instr[19:15];
            dec.rs2    = in_instr[24:20];
            dec.funct3 = f3;
            dec.imm    = imm_b;
            alu_op     = BRANCH;
            bad_fields = (f3 == 3'b010) || (f3 == 3'b011);
         end
         OP_UTYPE_AUIPC, OP_UTYPE_LUI: begin
            dec.rd     = in_instr[11:7];
            dec.imm    = imm_u;
            alu_op     = MEMORY_ACCESS;
         end
         OP_JTYPE: begin
            dec.rd     = in_instr[11:7];
            dec.imm    = imm_j;
         end
         default: begin
            unknown_op = 1'b1;
         end
      endcase
      dec.alu_control = alu_decoder(alu_op, f3, f7[5]);
      dec.illegal     = unknown_op || (CHECK_ILLEGAL && bad_fields);
      if (dec.illegal) begin
         dec.rd  = '0;
         dec.rs1 = '0;
         dec.rs2 = '0;
         dec.imm = '0;
      end
   end

   entry_t           mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             push;
   logic             pop;
   entry_t           head;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   // A pop in the same cycle frees a slot, so a full queue can still accept.
   // Holding reset also closes the input side.
   assign out_valid = (occupancy != '0);
   assign in_ready  = rst_n && !flush &&
                      ((occupancy < OCC_W'(DEPTH)) || (out_valid && out_ready));
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready && !flush;

   // Entry storage has no reset; the head is masked while the queue is empty.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= dec;
      end
   end

   // Pointer and occupancy bookkeeping. Flush wins over any push or pop.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         occupancy <= '0;
      end else if (flush) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         occupancy <= '0;
      end else begin
         if (push) begin
            wr_ptr <= ptr_inc(wr_ptr);
         end
         if (pop) begin
            rd_ptr <= ptr_inc(rd_ptr);
         end
         if (push && !pop) begin
            occupancy <= occupancy + 1'b1;
         end else if (pop && !push) begin
            occupancy <= occupancy - 1'b1;
         end
      end
   end

   assign head            = out_valid ? mem[rd_ptr] : '0;
   assign out_pc          = head.pc;
   assign out_opcode      = head.opcode;
   assign out_funct3      = head.funct3;
   assign out_funct7      = head.funct7;
   assign out_rd          = head.rd;
   assign out_rs1         = head.rs1;
   assign out_rs2         = head.rs2;
   assign out_imm         = head.imm;
   assign out_alu_control = head.alu_control;
   assign out_illegal     = head.illegal;

endmodule

// File: tb/tb_decode_queue.sv
// Testbench for decode_queue. Two instances share one set of inputs: the
// default (full illegal check) and one with CHECK_ILLEGAL=0. A queue of raw
// {pc, instr} pairs models the FIFO; the expected head record is decoded
// from that pair by a reference decoder written from the ISA field rules.
module tb_decode_queue;

   localparam int DEPTH = 2;

   typedef struct packed {
      logic [31:0] pc;
      logic [6:0]  opcode;
      logic [2:0]  f3;
      logic [6:0]  f7;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [31:0] imm;
      logic [3:0]  alu;
      logic        ill;
   } ent_t;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } raw_t;

   localparam logic [6:0] OPS [9] = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h23,
                                      7'h63, 7'h17, 7'h37, 7'h6F};

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        flush = 1'b0;
   logic        in_valid = 1'b0;
   logic        out_ready = 1'b0;
   logic [31:0] in_instr = '0;
   logic [31:0] in_pc = '0;

   logic        in_ready, out_valid, out_illegal;
   logic [31:0] out_pc, out_imm;
   logic [6:0]  out_opcode, out_funct7;
   logic [2:0]  out_funct3;
   logic [4:0]  out_rd, out_rs1, out_rs2;
   logic [3:0]  out_alu_control;
   logic [1:0]  occupancy;

   logic        n_in_ready, n_out_valid, n_out_illegal;
   logic [31:0] n_out_pc, n_out_imm;
   logic [6:0]  n_out_opcode, n_out_funct7;
   logic [2:0]  n_out_funct3;
   logic [4:0]  n_out_rd, n_out_rs1, n_out_rs2;
   logic [3:0]  n_out_alu_control;
   logic [1:0]  n_occupancy;

   ent_t obs, nobs;
   raw_t mq[$];
   int   checks = 0;
   int   errors = 0;

   decode_queue #(.DEPTH(DEPTH), .PC_WIDTH(32), .CHECK_ILLEGAL(1'b1)) u_dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
      .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
      .out_opcode(out_opcode), .out_funct3(out_funct3), .out_funct7(out_funct7),
      .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_imm(out_imm),
      .out_alu_control(out_alu_control), .out_illegal(out_illegal),
      .occupancy(occupancy)
   );

   decode_queue #(.DEPTH(DEPTH), .PC_WIDTH(32), .CHECK_ILLEGAL(1'b0)) u_dut_nochk (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .in_valid(in_valid), .in_ready(n_in_ready), .in_instr(in_instr), .in_pc(in_pc),
      .out_valid(n_out_valid), .out_ready(out_ready), .out_pc(n_out_pc),
      .out_opcode(n_out_opcode), .out_funct3(n_out_funct3), .out_funct7(n_out_funct7),
      .out_rd(n_out_rd), .out_rs1(n_out_rs1), .out_rs2(n_out_rs2), .out_imm(n_out_imm),
      .out_alu_control(n_out_alu_control), .out_illegal(n_out_illegal),
      .occupancy(n_occupancy)
   );

   assign obs  = {out_pc, out_opcode, out_funct3, out_funct7, out_rd, out_rs1,
                  out_rs2, out_imm, out_alu_control, out_illegal};
   assign nobs = {n_out_pc, n_out_opcode, n_out_funct3, n_out_funct7, n_out_rd,
                  n_out_rs1, n_out_rs2, n_out_imm, n_out_alu_control, n_out_illegal};

   always #5 clk = ~clk;

   // Register-op ALU selection: funct3 picks the operation, funct7[5] picks sub/sra.
   function automatic logic [3:0] r_alu(input logic [2:0] f3, input logic [6:0] f7);
      case (f3)
         3'd0:    return f7[5] ? 4'h1 : 4'h0;
         3'd1:    return 4'h2;
         3'd2:    return 4'h3;
         3'd3:    return 4'h4;
         3'd4:    return 4'h5;
         3'd5:    return f7[5] ? 4'h7 : 4'h6;
         3'd6:    return 4'h8;
         default: return 4'h9;
      endcase
   endfunction

   // Reference decoder: immediates built arithmetically from the field rules.
   function automatic ent_t ref_decode(input logic [31:0] i, input logic [31:0] pc,
                                       input bit chk);
      ent_t       e;
      logic [6:0] op;
      logic [2:0] f3;
      logic [6:0] f7;
      bit         known;
      bit         bad;
      int         s31;
      int         ival;
      op    = i[6:0];
      f3    = i[14:12];
      f7    = i[31:25];
      known = 1'b1;
      bad   = 1'b0;
      s31   = $signed(i) >>> 31;
      ival  = $signed(i) >>> 20;
      e        = '0;
      e.pc     = pc;
      e.opcode = op;
      e.alu    = 4'hF;
      case (op)
         7'h33: begin
            e.rd = i[11:7]; e.rs1 = i[19:15]; e.rs2 = i[24:20];
            e.f3 = f3; e.f7 = f7; e.alu = r_alu(f3, f7);
            bad = !(f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)));
         end
         7'h13: begin
            e.rd = i[11:7]; e.rs1 = i[19:15]; e.f3 = f3; e.f7 = f7; e.imm = ival;
            bad = (f3 == 3'd1 && f7 != 7'h00) ||
                  (f3 == 3'd5 && f7 != 7'h00 && f7 != 7'h20);
         end
         7'h03: begin
            e.rd = i[11:7]; e.rs1 = i[19:15]; e.f3 = f3; e.imm = ival; e.alu = 4'h0;
            bad = (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
         end
         7'h67: begin
            e.rd = i[11:7]; e.rs1 = i[19:15]; e.f3 = f3; e.imm = ival; e.alu = 4'h0;
            bad = (f3 != 3'd0);
         end
         7'h23: begin
            e.rs1 = i[19:15]; e.rs2 = i[24:20]; e.f3 = f3; e.alu = 4'h0;
            e.imm = ((($signed(i) >>> 25)) * 32) + int'(i[11:7]);
            bad = (f3 > 3'd2);
         end
         7'h63: begin
            e.rs1 = i[19:15]; e.rs2 = i[24:20]; e.f3 = f3; e.alu = 4'h1;
            e.imm = s31 * 4096 + int'(i[7]) * 2048 + int'(i[30:25]) * 32 +
                    int'(i[11:8]) * 2;
            bad = (f3 == 3'd2 || f3 == 3'd3);
         end
         7'h17, 7'h37: begin
            e.rd = i[11:7]; e.imm = i & 32'hFFFF_F000; e.alu = 4'h0;
         end
         7'h6F: begin
            e.rd = i[11:7];
            e.imm = s31 * 1048576 + int'(i[19:12]) * 4096 + int'(i[20]) * 2048 +
                    int'(i[30:21]) * 2;
         end
         default: known = 1'b0;
      endcase
      e.ill = !known || (chk && bad);
      if (e.ill) begin
         e.rd = '0; e.rs1 = '0; e.rs2 = '0; e.imm = '0;
      end
      return e;
   endfunction

   function automatic ent_t exp_head(input bit chk);
      if (mq.size() == 0) return '0;
      return ref_decode(mq[0].instr, mq[0].pc, chk);
   endfunction

   function automatic bit exp_ready();
      return rst_n && !flush && (mq.size() < DEPTH || (mq.size() > 0 && out_ready));
   endfunction

   task automatic drive(input bit v, input logic [31:0] ins, input logic [31:0] pc,
                        input bit ordy, input bit fl);
      in_valid  = v;
      in_instr  = ins;
      in_pc     = pc;
      out_ready = ordy;
      flush     = fl;
   endtask

   // Advance one clock and update the model; ends 1 time unit after the edge.
   task automatic cycle();
      bit acc;
      bit pop;
      acc = in_valid && exp_ready();
      pop = (mq.size() > 0) && out_ready && !flush;
      @(posedge clk);
      #1;
      if (flush) begin
         mq.delete();
      end else begin
         if (pop) void'(mq.pop_front());
         if (acc) mq.push_back('{in_pc, in_instr});
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      drive(1'b1, 32'h0051_0093, 32'h0, 1'b1, 1'b0);
      @(posedge clk);
      #1;
      checks++;
      if (in_ready !== 1'b0) begin
         errors++; $display("[TB] FAIL reset_in_ready got %b want 0", in_ready);
      end
      checks++;
      if (out_valid !== 1'b0 || occupancy !== 2'd0) begin
         errors++;
         $display("[TB] FAIL reset_state got valid=%b occ=%0d want 0/0", out_valid, occupancy);
      end
      checks++;
      if (obs !== '0) begin
         errors++; $display("[TB] FAIL reset_fields got %h want 0", obs);
      end
      rst_n = 1'b1;
      mq.delete();
      drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
   endtask

   task automatic test_single();
      drive(1'b1, 32'h0051_0093, 32'h100, 1'b0, 1'b0);
      #1;
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         errors++;
         $display("[TB] FAIL single_pre got ready=%b valid=%b want 1/0", in_ready, out_valid);
      end
      cycle();
      drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
      checks++;
      if (out_valid !== 1'b1 || occupancy !== 2'd1) begin
         errors++;
         $display("[TB] FAIL single_valid got valid=%b occ=%0d want 1/1", out_valid, occupancy);
      end
      checks++;
      if ({out_rd, out_rs1, out_rs2, out_imm, out_funct3, out_illegal, out_pc} !==
          {5'd1, 5'd2, 5'd0, 32'd5, 3'd0, 1'b0, 32'h100}) begin
         errors++;
         $display("[TB] FAIL single_fields got rd=%0d rs1=%0d rs2=%0d imm=%h f3=%0d ill=%b pc=%h",
                  out_rd, out_rs1, out_rs2, out_imm, out_funct3, out_illegal, out_pc);
      end
      checks++;
      if (obs !== exp_head(1'b1)) begin
         errors++; $display("[TB] FAIL single_head got %h want %h", obs, exp_head(1'b1));
      end
      out_ready = 1'b1;
      cycle();
      out_ready = 1'b0;
      checks++;
      if (out_valid !== 1'b0 || obs !== '0) begin
         errors++; $display("[TB] FAIL single_drain got valid=%b fields=%h want 0", out_valid, obs);
      end
   endtask

   task automatic test_imm_formats();
      logic [31:0] ins   [3] = '{32'h0011_2223, 32'hFE00_0EE3, 32'h1234_50B7};
      logic [31:0] imm_e [3] = '{32'd4, 32'hFFFF_FFFC, 32'h1234_5000};
      logic [14:0] regs  [3] = '{{5'd0, 5'd2, 5'd1}, {5'd0, 5'd0, 5'd0}, {5'd1, 5'd0, 5'd0}};
      for (int k = 0; k < 3; k++) begin
         drive(1'b1, ins[k], 32'h200 + 32'(4 * k), 1'b1, 1'b0);
         cycle();
         checks++;
         if (out_imm !== imm_e[k] || {out_rd, out_rs1, out_rs2} !== regs[k]) begin
            errors++;
            $display("[TB] FAIL imm_fmt%0d got imm=%h rd/rs1/rs2=%0d/%0d/%0d want imm=%h regs=%h",
                     k, out_imm, out_rd, out_rs1, out_rs2, imm_e[k], regs[k]);
         end
         checks++;
         if (obs !== exp_head(1'b1)) begin
            errors++; $display("[TB] FAIL imm_head%0d got %h want %h", k, obs, exp_head(1'b1));
         end
      end
      drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      cycle();
      out_ready = 1'b0;
   endtask

   task automatic test_backpressure();
      logic [31:0] ins [3] = '{32'h0031_0193, 32'h0042_0213, 32'h0053_0293};
      for (int k = 0; k < 3; k++) begin
         drive(1'b1, ins[k], 32'h300 + 32'(4 * k), 1'b0, 1'b0);
         #1;
         checks++;
         if (in_ready !== (k < 2)) begin
            errors++; $display("[TB] FAIL bp_ready%0d got %b want %b", k, in_ready, k < 2);
         end
         if (k == 2) begin
            checks++;
            if (occupancy !== 2'd2) begin
               errors++; $display("[TB] FAIL bp_full_occ got %0d want 2", occupancy);
            end
         end
         cycle();
      end
      checks++;
      if (out_pc !== 32'h300 || obs !== exp_head(1'b1)) begin
         errors++; $display("[TB] FAIL bp_hold got pc=%h want 300", out_pc);
      end
      out_ready = 1'b1;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
         errors++; $display("[TB] FAIL bp_pop_ready got %b want 1", in_ready);
      end
      cycle();
      checks++;
      if (out_pc !== 32'h304 || occupancy !== 2'd2 || obs !== exp_head(1'b1)) begin
         errors++; $display("[TB] FAIL bp_pushpop got pc=%h occ=%0d want 304/2", out_pc, occupancy);
      end
      drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      cycle();
      checks++;
      if (out_pc !== 32'h308 || obs !== exp_head(1'b1)) begin
         errors++; $display("[TB] FAIL bp_order got pc=%h want 308", out_pc);
      end
      cycle();
      out_ready = 1'b0;
   endtask

   task automatic test_illegal();
      logic [31:0] ins [3] = '{32'h0000_0000, 32'h4000_1033, 32'h0000_1067};
      for (int k = 0; k < 3; k++) begin
         drive(1'b1, ins[k], 32'h400 + 32'(4 * k), 1'b1, 1'b0);
         cycle();
         checks++;
         if (out_illegal !== 1'b1 || {out_rd, out_rs1, out_rs2, out_imm} !== '0) begin
            errors++;
            $display("[TB] FAIL illegal%0d got ill=%b rd=%0d rs1=%0d rs2=%0d imm=%h want 1/0",
                     k, out_illegal, out_rd, out_rs1, out_rs2, out_imm);
         end
         checks++;
         if (n_out_illegal !== (k == 0)) begin
            errors++; $display("[TB] FAIL nochk_illegal%0d got %b want %b", k, n_out_illegal, k == 0);
         end
         checks++;
         if (obs !== exp_head(1'b1) || nobs !== exp_head(1'b0)) begin
            errors++; $display("[TB] FAIL illegal_head%0d got %h want %h", k, obs, exp_head(1'b1));
         end
      end
      drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      cycle();
      out_ready = 1'b0;
   endtask

   task automatic test_flush();
      for (int k = 0; k < 2; k++) begin
         drive(1'b1, 32'h0051_0093, 32'h500 + 32'(4 * k), 1'b0, 1'b0);
         cycle();
      end
      drive(1'b1, 32'h0011_2223, 32'h508, 1'b1, 1'b1);
      #1;
      checks++;
      if (in_ready !== 1'b0) begin
         errors++; $display("[TB] FAIL flush_ready got %b want 0", in_ready);
      end
      cycle();
      drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
      checks++;
      if (out_valid !== 1'b0 || occupancy !== 2'd0) begin
         errors++;
         $display("[TB] FAIL flush_empty got valid=%b occ=%0d want 0/0", out_valid, occupancy);
      end
      cycle();
      checks++;
      if (out_valid !== 1'b0) begin
         errors++; $display("[TB] FAIL flush_discard got valid=%b want 0", out_valid);
      end
   endtask

   task automatic test_random();
      logic [31:0] ins;
      for (int n = 0; n < 400; n++) begin
         ins = $urandom;
         if ($urandom_range(0, 9) != 0) ins[6:0] = OPS[$urandom_range(0, 8)];
         if ($urandom_range(0, 1) != 0) ins[31:25] = ($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00;
         drive($urandom_range(0, 3) != 0, ins, $urandom, $urandom_range(0, 2) != 0,
               $urandom_range(0, 15) == 0);
         #1;
         checks++;
         if (in_ready !== exp_ready() || n_in_ready !== exp_ready()) begin
            errors++; $display("[TB] FAIL rand_ready%0d got %b want %b", n, in_ready, exp_ready());
         end
         checks++;
         if (out_valid !== (mq.size() > 0) || occupancy !== 2'(mq.size())) begin
            errors++;
            $display("[TB] FAIL rand_occ%0d got valid=%b occ=%0d want occ=%0d",
                     n, out_valid, occupancy, mq.size());
         end
         checks++;
         if (obs !== exp_head(1'b1)) begin
            errors++; $display("[TB] FAIL rand_head%0d got %h want %h", n, obs, exp_head(1'b1));
         end
         checks++;
         if (nobs !== exp_head(1'b0)) begin
            errors++; $display("[TB] FAIL rand_nochk%0d got %h want %h", n, nobs, exp_head(1'b0));
         end
         cycle();
      end
      drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
      cycle();
      flush = 1'b0;
   endtask

   task automatic test_reset_mid();
      drive(1'b1, 32'h0011_2223, 32'h600, 1'b0, 1'b0);
      cycle();
      drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
      #1;
      checks++;
      if (out_valid !== 1'b1) begin
         errors++; $display("[TB] FAIL rmid_pre got valid=%b want 1", out_valid);
      end
      rst_n = 1'b0;
      #1;
      mq.delete();
      checks++;
      if (out_valid !== 1'b0 || occupancy !== 2'd0) begin
         errors++;
         $display("[TB] FAIL rmid_async got valid=%b occ=%0d want 0/0", out_valid, occupancy);
      end
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      drive(1'b1, 32'h0051_0093, 32'h700, 1'b0, 1'b0);
      cycle();
      drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
      checks++;
      if (out_rd !== 5'd1 || out_imm !== 32'd5 || out_pc !== 32'h700 || obs !== exp_head(1'b1)) begin
         errors++;
         $display("[TB] FAIL rmid_after got rd=%0d imm=%h pc=%h want 1/5/700", out_rd, out_imm, out_pc);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_imm_formats();
      test_backpressure();
      test_illegal();
      test_flush();
      test_random();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/decode_queue.md
Name: decode_queue

Overview:
- Registered, buffered instruction-decode stage placed between fetch and execute.
- Accepts raw 32-bit instructions with their PC over a valid/ready handshake.
- Decodes each instruction at enqueue time into opcode, register indices, funct fields, sign-extended immediate, ALU control and an illegal-instruction flag.
- Holds up to DEPTH decoded entries in a FIFO and presents them in order to execute over a second valid/ready handshake, with a synchronous flush for branch/jump redirects.

Parameters:
- DEPTH, 2, number of decoded-instruction entries buffered; legal values 1 to 8.
- PC_WIDTH, 32, width of the PC carried alongside each instruction.
- CHECK_ILLEGAL, 1, 1 = full illegal-encoding check; 0 = only unknown opcodes are flagged.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous queue clear.
- in_valid  in  1  fetch presents an instruction.
- in_ready  out  1  queue can accept this cycle.
- in_instr  in  32  raw instruction.
- in_pc  in  PC_WIDTH  instruction address.
- out_valid  out  1  head entry valid.
- out_ready  in  1  execute consumes the head entry.
- out_pc  out  PC_WIDTH  head PC.
- out_opcode  out  7  opcode_t.
- out_funct3  out  3  instr[14:12], or 0 where not applicable.
- out_funct7  out  7  instr[31:25] for RType/IType_logic, else 0.
- out_rd, out_rs1, out_rs2  out  5 each  register indices, 0 where unused.
- out_imm  out  32  imm_t sign-extended immediate.
- out_alu_control  out  4  ALUControl from the existing ALUdecoder.
- out_illegal  out  1  entry is an illegal encoding.
- occupancy  out  $clog2(DEPTH+1)  number of valid entries.

Behaviour:
- Reset: rst_n=0 asynchronously clears read/write pointers and occupancy.
  - While reset is held, out_valid=0 and in_ready=0.
  - All out_* data fields read 0 while the queue is empty; entry storage need not be reset.
  - An operation in flight at reset assertion is lost.
- Enqueue:
  - Accept when in_valid && in_ready.
  - in_ready = !flush && (occupancy<DEPTH || (out_valid && out_ready)), i.e. a simultaneous pop frees a slot in the same cycle.
  - The decode is combinational on in_instr; the decoded fields are written into the tail entry.
- Latency: an entry written at edge N is visible on the out_* ports after edge N, so out_valid rises 1 cycle after acceptance. There is no same-cycle bypass.
- Dequeue:
  - Pop when out_valid && out_ready.
  - Head fields stay stable while out_valid=1 and out_ready=0.
- Simultaneous push and pop: occupancy is unchanged and both pointers advance.
- Pointers wrap modulo DEPTH. Full is occupancy==DEPTH; empty is occupancy==0.
- Flush: at the next edge, occupancy=0 and both pointers reset.
  - Any push or pop in that cycle is discarded.
  - in_ready=0 during flush, and out_valid drops the cycle after.
- Field extraction:
  - rd: RType, IType_*, UType_*, JType.
  - rs1: RType, IType_*, SType, BType.
  - rs2: RType, SType, BType.
  - funct3: RType, IType_logic, IType_load, IType_jalr, SType, BType.
- Immediates:
  - I: sign-extended instr[31:20].
  - S: {instr[31:25], instr[11:7]}.
  - B: {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
  - J: {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
  - U: {instr[31:12], 12'b0}.
  - imm is 0 for RType.
- alu_op mapping:
  - RType → REGISTER_OPERATION.
  - IType_load, IType_jalr, SType, UType_auipc, UType_lui → MEMORY_ACCESS.
  - BType → BRANCH.
  - All others → UNSET.
- Illegal when any of the following holds:
  - opcode is not one of the nine opcode_t values.
  - With CHECK_ILLEGAL=1, also:
    - RType funct7 not in {0x00, 0x20}, or funct7=0x20 with funct3 not in {000, 101}.
    - IType_logic funct3=001 with funct7≠0, or funct3=101 with funct7 not in {0x00, 0x20}.
    - IType_jalr funct3≠000.
    - IType_load funct3 in {011, 110, 111}.
    - SType funct3>010.
    - BType funct3 in {010, 011}.
- Illegal entries are still queued with out_illegal=1, and rd/rs1/rs2/imm are forced to 0 so no register write or hazard is implied.

Test Plan:
- Single instruction: 0x00510093 (addi x1,x2,5), pc 0x100 → next cycle out_valid=1, rd=1, rs1=2, rs2=0, imm=0x00000005, funct3=000, illegal=0, out_pc=0x100.
- Immediate formats, back-to-back:
  - 0x00112223 (sw x1,4(x2)) → rs1=2, rs2=1, rd=0, imm=4.
  - 0xFE000EE3 (beq x0,x0,-4) → imm=0xFFFFFFFC.
  - 0x123450B7 (lui) → rd=1, imm=0x12345000.
- Backpressure, DEPTH=2, out_ready=0, three pushes:
  - in_ready=0 after 2 accepts and occupancy=2; the third instruction is held.
  - Raising out_ready pops in order, with a simultaneous push accepted in the same cycle.
- Illegal encodings, each gives illegal=1 with rd/rs/imm=0:
  - 0x00000000.
  - 0x40001033 (funct7=0x20, funct3=001).
  - 0x00001067 (jalr funct3=001).
  - With CHECK_ILLEGAL=0, only 0x00000000 is flagged.
- Flush: with 2 entries queued, flush=1 for one cycle while in_valid=1 → the next cycle out_valid=0, occupancy=0, and the offered instruction is not enqueued.
- Reset mid-operation: assert rst_n=0 asynchronously with 1 entry queued → out_valid and occupancy drop immediately; after release the first push is decoded correctly.
